subtrator16_seq: RTL and testbench
==================================

// Module: subtrator16_seq
// PURPOSE
//  Multi-cycle subtractor: S = A - B - Bin over DATA_W bits, one SLICE_W-bit slice per clock, LSB slice first.
//  Inverse operation of the 16-bit slice adder; the borrow is carried between slices in a register, not a ripple chain.
//  Serves the RPN ALU's SUB/CMP operations; start/busy/done handshake with the stack controller.
// PARAMETERS
//  DATA_W   16  operand/result width; must be an integer multiple of SLICE_W
//  SLICE_W  8   bits processed per clock; NS = DATA_W/SLICE_W slices (default NS=2)
// PORTS
//  clk    in   1        rising-edge clock
//  rst    in   1        asynchronous, active-high reset
//  start  in   1        request; accepted only in IDLE or DONE
//  A      in   DATA_W   minuend, sampled on the accepting edge
//  B      in   DATA_W   subtrahend, sampled on the accepting edge
//  Bin    in   1        borrow-in, sampled on the accepting edge
//  S      out  DATA_W   difference; valid from done until the next accepted start
//  Bo     out  1        borrow-out (1 = unsigned A < B + Bin)
//  busy   out  1        high while in CALC
//  done   out  1        one-cycle pulse, result valid
//  Z      out  1        [SUB16_FLAGS_EN] S == 0
//  V      out  1        [SUB16_FLAGS_EN] two's-complement overflow
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, slice index=0, S=0, Bo=0, busy=0, done=0, Z=0, V=0; operand regs cleared.
//  States: IDLE -(start)-> CALC; CALC -(index==NS-1)-> DONE; DONE -(start)-> CALC, -(!start)-> IDLE.
//  Accepting edge: latch A, B; borrow reg <= Bin; index <= 0; busy <= 1.
//  Each CALC edge: slice i = A[i] + ~B[i] + ~borrow (SLICE_W-bit add); write S[i]; borrow <= ~carry_out; index++.
//  On the last slice: Bo <= ~carry_out of the MSB slice; state <= DONE.
//  Latency: start accepted at edge 0 -> slices at edges 1..NS -> done=1 in the cycle after edge NS (default: 2 edges).
//  busy=1 exactly NS cycles; done=1 exactly one cycle; busy and done are never both 1.
//  start while in CALC: ignored; operands and result are not disturbed.
//  start in DONE: accepted (back-to-back); done is high for that cycle and busy rises on the next edge.
//  S is updated slice by slice during CALC; consumers read it only when done=1 or afterwards in IDLE.
//  S and Bo hold their values in IDLE indefinitely.
//  A/B/Bin changes after the accepting edge: no effect on the current operation.
//  Wrap-around: result is modulo 2^DATA_W; Bo reports the unsigned underflow.
//  Reset asserted mid-CALC: operation is aborted, done is never pulsed, all outputs return to reset values.
// CONFIGURATION
//  SUB16_FLAGS_EN defined: Z and V are ports, registered together with Bo on the last slice edge, and hold until the next done.
//    Z = (S == 0); V = (A[MSB] != B[MSB]) && (S[MSB] != A[MSB]).
//  SUB16_FLAGS_EN undefined: Z, V and their logic are absent; port list ends at done.
// TESTING
//  1) A=0x1234, B=0x0001, Bin=0, start 1 cycle -> busy 2 cycles, done pulse, S=0x1233, Bo=0, Z=0, V=0.
//  2) A=0x0000, B=0x0001, Bin=0 -> S=0xFFFF, Bo=1, V=0; checks the borrow across the slice boundary.
//  3) A=0x8000, B=0x0001, Bin=0 -> S=0x7FFF, Bo=0, V=1; then A=0x00FF, B=0x00FE, Bin=1 -> S=0x0000, Z=1.
//  4) start held high continuously with new A/B every DONE -> back-to-back results, one done per 3 cycles; start pulses in CALC ignored.
//  5) Assert rst during the first CALC cycle -> S=0, Bo=0, busy=0, no done; the next start computes correctly.
//  6) Random A/B/Bin, 10k ops, DATA_W=16 and DATA_W=32/SLICE_W=8 -> S, Bo, Z, V match the reference model; busy length = NS.

Source files
------------

// File: rtl/subtrator16_seq.sv
// Sequential slice subtractor: S = A - B - Bin, one SLICE_W slice per clock.
// Optional flags Z/V are built when SUB16_FLAGS_EN is defined.
module subtrator16_seq #(
    parameter int DATA_W  = 16,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic              Bin,
    output logic [DATA_W-1:0] S,
    output logic              Bo,
    output logic              busy,
    output logic              done
`ifdef SUB16_FLAGS_EN
    ,
    output logic              Z,
    output logic              V
`endif
);

    localparam int NS = DATA_W / SLICE_W;
    localparam int IW = (NS > 1) ? $clog2(NS) : 1;
    localparam logic [IW-1:0] LAST = IW'(NS - 1);
    localparam int MSB = DATA_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] s_q, s_d;
    logic              borrow_q, borrow_d;
    logic              bo_q, bo_d;

    logic [SLICE_W-1:0] a_sl;
    logic [SLICE_W-1:0] b_sl;
    logic [SLICE_W:0]   sum;
    logic [DATA_W-1:0]  s_next;

`ifdef SUB16_FLAGS_EN
    logic z_q, z_d;
    logic v_q, v_d;
`endif

    // Current slice: add A + ~B + ~borrow; carry-out inverted is the borrow
    always_comb begin
        a_sl   = a_q[idx_q*SLICE_W +: SLICE_W];
        b_sl   = b_q[idx_q*SLICE_W +: SLICE_W];
        sum    = {1'b0, a_sl} + {1'b0, ~b_sl}
               + {{SLICE_W{1'b0}}, ~borrow_q};
        s_next = s_q;
        s_next[idx_q*SLICE_W +: SLICE_W] = sum[SLICE_W-1:0];
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        s_d      = s_q;
        borrow_d = borrow_q;
        bo_d     = bo_q;
`ifdef SUB16_FLAGS_EN
        z_d      = z_q;
        v_d      = v_q;
`endif
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = CALC;
                    a_d      = A;
                    b_d      = B;
                    borrow_d = Bin;
                    idx_d    = '0;
                end else begin
                    state_d  = IDLE;
                end
            end
            CALC: begin
                s_d      = s_next;
                borrow_d = ~sum[SLICE_W];
                idx_d    = idx_q + IW'(1);
                if (idx_q == LAST) begin
                    bo_d    = ~sum[SLICE_W];
                    idx_d   = '0;
                    state_d = DONE;
`ifdef SUB16_FLAGS_EN
                    z_d = (s_next == '0);
                    v_d = (a_q[MSB] != b_q[MSB])
                       && (s_next[MSB] != a_q[MSB]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            s_q      <= '0;
            borrow_q <= 1'b0;
            bo_q     <= 1'b0;
`ifdef SUB16_FLAGS_EN
            z_q      <= 1'b0;
            v_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            s_q      <= s_d;
            borrow_q <= borrow_d;
            bo_q     <= bo_d;
`ifdef SUB16_FLAGS_EN
            z_q      <= z_d;
            v_q      <= v_d;
`endif
        end
    end

    assign S    = s_q;
    assign Bo   = bo_q;
    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);
`ifdef SUB16_FLAGS_EN
    assign Z    = z_q;
    assign V    = v_q;
`endif

endmodule

// File: tb/tb_subtrator16_seq.sv
// Bench for subtrator16_seq: 16/8 and 32/8 instances.
// Table vectors, back-to-back, reset abort and random ops.
module tb_subtrator16_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start16 = 1'b0, start32 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        bin16 = 1'b0, bin32 = 1'b0;
    logic [15:0] s16;
    logic [31:0] s32;
    logic        bo16, bo32, busy16, busy32, done16, done32;
`ifdef SUB16_FLAGS_EN
    logic        z16, v16, z32, v32;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    subtrator16_seq #(.DATA_W(16), .SLICE_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start16),
        .A(a16), .B(b16), .Bin(bin16),
        .S(s16), .Bo(bo16), .busy(busy16), .done(done16)
`ifdef SUB16_FLAGS_EN
        , .Z(z16), .V(v16)
`endif
    );

    subtrator16_seq #(.DATA_W(32), .SLICE_W(8)) dut32 (
        .clk(clk), .rst(rst), .start(start32),
        .A(a32), .B(b32), .Bin(bin32),
        .S(s32), .Bo(bo32), .busy(busy32), .done(done32)
`ifdef SUB16_FLAGS_EN
        , .Z(z32), .V(v32)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] s;
        logic        bo;
        logic        z;
        logic        v;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer subtraction over w bits
    task automatic ref_sub(input int w, input logic [31:0] a,
                           input logic [31:0] b, input logic bin,
                           output logic [31:0] s, output logic bo,
                           output logic z, output logic v);
        longint mask, diff;
        mask = (longint'(1) << w) - 1;
        diff = (longint'(a) & mask) - (longint'(b) & mask) - longint'(bin);
        s    = 32'(diff & mask);
        bo   = (diff < 0);
        z    = (s == 0);
        v    = (a[w-1] != b[w-1]) && (s[w-1] != a[w-1]);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic bin, input logic [15:0] es16,
                         input logic eb16, input logic ez16,
                         input logic ev16);
        logic [31:0] es32;
        logic eb32, ez32, ev32;
        bit seen16, seen32;
        int nb16, nb32;
        ref_sub(32, a, b, bin, es32, eb32, ez32, ev32);
        seen16 = 0; seen32 = 0; nb16 = 0; nb32 = 0;
        @(negedge clk);
        start16 = 1'b1; start32 = 1'b1;
        a16 = a[15:0]; b16 = b[15:0]; bin16 = bin;
        a32 = a; b32 = b; bin32 = bin;
        for (int k = 0; k < 12 && !(seen16 && seen32); k++) begin
            @(negedge clk);
            if (k == 0) begin
                start16 = 1'b0; start32 = 1'b0;
                a16 = 16'($urandom); b16 = 16'($urandom);
                a32 = $urandom; b32 = $urandom;
                bin16 = 1'($urandom); bin32 = 1'($urandom);
            end
            if (busy16 && done16) chk("busy_and_done16", 1, 0);
            if (busy32 && done32) chk("busy_and_done32", 1, 0);
            if (busy16) nb16++;
            if (busy32) nb32++;
            if (done16) begin
                if (seen16) chk("done_len16", 1, 0);
                else begin
                    seen16 = 1;
                    chk("s16", s16, es16);
                    chk("bo16", bo16, eb16);
                    chk("busy_len16", nb16, 2);
`ifdef SUB16_FLAGS_EN
                    chk("z16", z16, ez16);
                    chk("v16", v16, ev16);
`endif
                end
            end
            if (done32) begin
                seen32 = 1;
                chk("s32", s32, es32);
                chk("bo32", bo32, eb32);
                chk("busy_len32", nb32, 4);
`ifdef SUB16_FLAGS_EN
                chk("z32", z32, ez32);
                chk("v32", v32, ev32);
`endif
            end
        end
        if (!seen16) chk("timeout16", 0, 1);
        if (!seen32) chk("timeout32", 0, 1);
    endtask

    initial begin
        logic [31:0] rs;
        logic rb, rz, rv;
        logic [15:0] ba[3], bb[3];
        logic        bc[3];
        int op, last_done;
        bit saw_done;

        tbl[0] = '{16'h1234, 16'h0001, 1'b0, 16'h1233, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{16'h00FF, 16'h00FE, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_s16", s16, 0);
        chk("rst_bo16", bo16, 0);
        chk("rst_busy16", busy16, 0);
        chk("rst_done16", done16, 0);
        chk("rst_s32", s32, 0);
        chk("rst_busy32", busy32, 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            do_op({16'h0, tbl[i].a}, {16'h0, tbl[i].b}, tbl[i].bin,
                  tbl[i].s, tbl[i].bo, tbl[i].z, tbl[i].v);
            repeat (5) @(negedge clk);
            chk("hold_s16", s16, tbl[i].s);
            chk("hold_bo16", bo16, tbl[i].bo);
        end

        ba[0] = 16'h1234; bb[0] = 16'h0001; bc[0] = 1'b0;
        ba[1] = 16'h0000; bb[1] = 16'h0001; bc[1] = 1'b0;
        ba[2] = 16'h0100; bb[2] = 16'h0001; bc[2] = 1'b1;
        @(negedge clk);
        start16 = 1'b1;
        a16 = ba[0]; b16 = bb[0]; bin16 = bc[0];
        op = 0; last_done = 0;
        for (int k = 0; k < 30 && op < 3; k++) begin
            @(negedge clk);
            if (done16) begin
                ref_sub(16, {16'h0, ba[op]}, {16'h0, bb[op]}, bc[op],
                        rs, rb, rz, rv);
                chk("b2b_s16", s16, rs[15:0]);
                chk("b2b_bo16", bo16, rb);
                if (op > 0) chk("b2b_period", k - last_done, 3);
                last_done = k;
                op++;
                if (op < 3) begin
                    a16 = ba[op]; b16 = bb[op]; bin16 = bc[op];
                end else begin
                    start16 = 1'b0;
                end
            end else begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                bin16 = 1'($urandom);
            end
        end
        if (op < 3) chk("b2b_timeout", op, 3);
        repeat (3) @(negedge clk);

        @(negedge clk);
        start16 = 1'b1;
        a16 = 16'h4000; b16 = 16'h0123; bin16 = 1'b0;
        @(negedge clk);
        start16 = 1'b0;
        chk("abort_busy_pre", busy16, 1);
        rst = 1'b1;
        #1;
        chk("abort_s16", s16, 0);
        chk("abort_bo16", bo16, 0);
        chk("abort_busy16", busy16, 0);
        chk("abort_done16", done16, 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done16 || busy16) saw_done = 1;
        end
        chk("abort_no_done", saw_done, 0);
        do_op(32'h0000_5555, 32'h0000_1111, 1'b1,
              16'h4443, 1'b0, 1'b0, 1'b0);

        for (int n = 0; n < 10000; n++) begin
            logic [31:0] ra, rbv;
            logic rc;
            ra = $urandom; rbv = $urandom; rc = 1'($urandom);
            if (n % 8 == 0) rbv = ra;
            ref_sub(16, ra, rbv, rc, rs, rb, rz, rv);
            do_op(ra, rbv, rc, rs[15:0], rb, rz, rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
